// File: rtl/tcdm_interconnect_pkg.sv
// Shared TCDM interconnect types: AMO opcodes and bank response tags.
package tcdm_interconnect_pkg;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_SWAP = 4'd1,
        AMO_ADD  = 4'd2,
        AMO_AND  = 4'd3,
        AMO_OR   = 4'd4,
        AMO_XOR  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MAXU = 4'd7,
        AMO_MIN  = 4'd8,
        AMO_MINU = 4'd9
    } amo_op_e;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_RDATA = 2'd1,
        RESP_ZERO  = 2'd2
    } resp_e;

endpackage

// File: rtl/tcdm_amo_alu.sv
// Combinational AMO datapath: combines the old memory word with the operand.
module tcdm_amo_alu
    import tcdm_interconnect_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  amo_op_e              i_op,
    input  logic [DataWidth-1:0] i_old,
    input  logic [DataWidth-1:0] i_operand,
    output logic [DataWidth-1:0] o_result,
    output logic                 o_valid_op
);

    logic w_slt;
    logic w_ult;

    assign w_slt = $signed(i_old) < $signed(i_operand);
    assign w_ult = i_old < i_operand;

    always_comb begin
        o_result   = '0;
        o_valid_op = 1'b1;
        case (i_op)
            AMO_SWAP: o_result = i_operand;
            AMO_ADD:  o_result = i_old + i_operand;
            AMO_AND:  o_result = i_old & i_operand;
            AMO_OR:   o_result = i_old | i_operand;
            AMO_XOR:  o_result = i_old ^ i_operand;
            AMO_MAX:  o_result = w_slt ? i_operand : i_old;
            AMO_MIN:  o_result = w_slt ? i_old : i_operand;
            AMO_MAXU: o_result = w_ult ? i_operand : i_old;
            AMO_MINU: o_result = w_ult ? i_old : i_operand;
            // NONE and reserved opcodes produce no write-back
            default:  o_valid_op = 1'b0;
        endcase
    end

endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM bank-side responder: req/gnt front end to a 1-cycle-latency SRAM,
// with AMOs executed as read followed by a stalled write-back cycle.
module tcdm_bank_responder
    import tcdm_interconnect_pkg::*;
#(
    parameter  int unsigned AddrWidth = 10,
    parameter  int unsigned DataWidth = 32,
    localparam int unsigned BeWidth   = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AddrWidth-1:0] add_i,
    input  logic                 wen_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic [3:0]           amo_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_AMO_WB = 1'b1
    } state_e;

    state_e               r_state;
    state_e               w_state_d;
    resp_e                r_resp;
    resp_e                w_resp_d;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_operand;
    amo_op_e              r_op;
    amo_op_e              w_amo;
    logic                 w_capture;
    logic [DataWidth-1:0] w_result;
    logic                 w_valid_op;

    assign w_amo = amo_op_e'(amo_i);
    assign gnt_o = req_i & (r_state == S_IDLE);

    // SRAM read data arrives during AMO_WB, so the ALU sees the old word directly
    tcdm_amo_alu #(
        .DataWidth (DataWidth)
    ) u_amo_alu (
        .i_op       (r_op),
        .i_old      (sram_rdata_i),
        .i_operand  (r_operand),
        .o_result   (w_result),
        .o_valid_op (w_valid_op)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_resp    <= RESP_NONE;
            r_addr    <= '0;
            r_operand <= '0;
            r_op      <= AMO_NONE;
        end else begin
            r_state <= w_state_d;
            r_resp  <= w_resp_d;
            if (w_capture) begin
                r_addr    <= add_i;
                r_operand <= wdata_i;
                r_op      <= w_amo;
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_resp_d     = RESP_NONE;
        w_capture    = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    sram_req_o  = 1'b1;
                    sram_addr_o = add_i;
                    if (w_amo != AMO_NONE) begin
                        w_capture = 1'b1;
                        w_resp_d  = RESP_RDATA;
                        w_state_d = S_AMO_WB;
                    end else if (wen_i) begin
                        sram_we_o    = 1'b1;
                        sram_wdata_o = wdata_i;
                        sram_be_o    = be_i;
                        w_resp_d     = RESP_ZERO;
                    end else begin
                        w_resp_d = RESP_RDATA;
                    end
                end
            end
            S_AMO_WB: begin
                sram_req_o   = w_valid_op;
                sram_we_o    = w_valid_op;
                sram_addr_o  = r_addr;
                sram_wdata_o = w_result;
                sram_be_o    = '1;
                w_state_d    = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    assign rdata_o = (r_resp == RESP_RDATA) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Self-checking bench for tcdm_bank_responder: SRAM model, transaction-level
// reference model, per-cycle compare process, directed and random traffic.
module tb_tcdm_bank_responder;

    logic        clk;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [9:0]  add_i;
    logic        wen_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [3:0]  amo_i;
    logic [31:0] rdata_o;
    logic        sram_req_o;
    logic        sram_we_o;
    logic [9:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_rdata_i;

    tcdm_bank_responder #(
        .AddrWidth (10),
        .DataWidth (32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .add_i        (add_i),
        .wen_i        (wen_i),
        .wdata_i      (wdata_i),
        .be_i         (be_i),
        .amo_i        (amo_i),
        .rdata_o      (rdata_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_be_o    (sram_be_o),
        .sram_rdata_i (sram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro: one access per cycle, read data registered
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    initial begin
        rd_q = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                rd_q <= mem[sram_addr_o];
            end
        end
    end
    assign sram_rdata_i = rd_q;

    int unsigned n_vec;
    int unsigned n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected memory image and pending transaction bookkeeping
    logic [31:0] ref_mem [0:1023];
    bit          busy;
    logic [9:0]  p_addr;
    logic [3:0]  p_op;
    logic [31:0] p_opnd;
    logic [31:0] ret_next;
    bit          rst_lvl;
    bit          armed;

    logic        exp_gnt, exp_sreq, exp_we;
    logic [9:0]  exp_addr;
    logic [31:0] exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    function automatic logic [31:0] amo_f(input logic [3:0] op, input logic [31:0] old,
                                          input logic [31:0] x, output bit ok);
        ok = 1'b1;
        case (op)
            4'd1: return x;
            4'd2: return old + x;
            4'd3: return old & x;
            4'd4: return old | x;
            4'd5: return old ^ x;
            4'd6: return ($signed(old) > $signed(x)) ? old : x;
            4'd7: return (old > x) ? old : x;
            4'd8: return ($signed(old) < $signed(x)) ? old : x;
            4'd9: return (old < x) ? old : x;
            default: begin ok = 1'b0; return 32'h0; end
        endcase
    endfunction

    task automatic do_cycle(input bit req, input logic [9:0] a, input bit wen,
                            input logic [31:0] d, input logic [3:0] be, input logic [3:0] amo);
        logic [31:0] res;
        bit          ok;
        @(posedge clk);
        #1;
        rst_ni  = rst_lvl;
        req_i   = req;
        add_i   = a;
        wen_i   = wen;
        wdata_i = d;
        be_i    = be;
        amo_i   = amo;
        exp_rdata = rst_lvl ? ret_next : 32'h0;
        exp_gnt = 0; exp_sreq = 0; exp_we = 0;
        exp_addr = '0; exp_wdata = '0; exp_be = '0;
        ret_next = '0;
        if (!rst_lvl) begin
            busy = 0;
        end else if (busy) begin
            res = amo_f(p_op, ref_mem[p_addr], p_opnd, ok);
            if (ok) begin
                exp_sreq = 1; exp_we = 1; exp_addr = p_addr;
                exp_wdata = res; exp_be = 4'hF;
                ref_mem[p_addr] = res;
            end
            busy = 0;
        end else if (req) begin
            exp_gnt = 1; exp_sreq = 1; exp_addr = a;
            if (amo != 4'd0) begin
                ret_next = ref_mem[a];
                busy = 1; p_addr = a; p_op = amo; p_opnd = d;
            end else if (wen) begin
                exp_we = 1; exp_wdata = d; exp_be = be;
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                ret_next = ref_mem[a];
            end
        end
        armed = 1;
    endtask

    task automatic idle();
        do_cycle(0, '0, 0, '0, '0, 4'd0);
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] v);
        do_cycle(1, a, 1, v, 4'hF, 4'd0);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("gnt", {31'h0, gnt_o}, {31'h0, exp_gnt});
            chk("rdata", rdata_o, exp_rdata);
            chk("sram_req", {31'h0, sram_req_o}, {31'h0, exp_sreq});
            if (exp_sreq) begin
                chk("sram_we", {31'h0, sram_we_o}, {31'h0, exp_we});
                chk("sram_addr", {22'h0, sram_addr_o}, {22'h0, exp_addr});
            end
            if (exp_we) begin
                chk("sram_wdata", sram_wdata_o, exp_wdata);
                chk("sram_be", {28'h0, sram_be_o}, {28'h0, exp_be});
            end
        end
    end

    initial begin
        n_vec = 0; n_bad = 0; busy = 0; armed = 0; ret_next = '0;
        p_addr = '0; p_op = '0; p_opnd = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        rst_ni = 0; req_i = 0; add_i = '0; wen_i = 0; wdata_i = '0; be_i = '0; amo_i = '0;
        rst_lvl = 0;
        repeat (3) idle();
        rst_lvl = 1;
        idle();

        // write then read back
        do_cycle(1, 10'd5, 1, 32'hDEADBEEF, 4'hF, 4'd0);
        @(negedge clk); chk("lit_wr_gnt", {31'h0, gnt_o}, 32'h1);
        do_cycle(1, 10'd5, 0, '0, 4'h0, 4'd0);
        @(negedge clk); chk("lit_rd_gnt", {31'h0, gnt_o}, 32'h1);
        chk("lit_wr_resp", rdata_o, 32'h0);
        idle();
        @(negedge clk); chk("lit_rd_5", rdata_o, 32'hDEADBEEF);

        // partial byte-enable write
        preload(10'd3, 32'h11223344);
        do_cycle(1, 10'd3, 1, 32'hAABBCCDD, 4'b0101, 4'd0);
        do_cycle(1, 10'd3, 0, '0, 4'h0, 4'd0);
        idle();
        @(negedge clk); chk("lit_be_merge", rdata_o, 32'h11BB33DD);

        // AMO ADD with stalled request during write-back
        preload(10'd7, 32'd10);
        do_cycle(1, 10'd7, 0, 32'd5, 4'hF, 4'd2);
        do_cycle(1, 10'd7, 0, '0, 4'h0, 4'd0);
        @(negedge clk); chk("lit_wb_gnt", {31'h0, gnt_o}, 32'h0);
        chk("lit_amo_old", rdata_o, 32'd10);
        do_cycle(1, 10'd7, 0, '0, 4'h0, 4'd0);
        idle();
        @(negedge clk); chk("lit_amo_new", rdata_o, 32'd15);

        // signed vs unsigned compare, add wrap
        preload(10'd2, 32'hFFFFFFFF);
        do_cycle(1, 10'd2, 0, 32'd1, 4'hF, 4'd6);
        idle(); idle();
        chk("lit_max", mem[2], 32'd1);
        preload(10'd2, 32'hFFFFFFFF);
        do_cycle(1, 10'd2, 0, 32'd1, 4'hF, 4'd7);
        idle(); idle();
        chk("lit_maxu", mem[2], 32'hFFFFFFFF);
        do_cycle(1, 10'd2, 0, 32'd1, 4'hF, 4'd2);
        idle(); idle();
        chk("lit_add_wrap", mem[2], 32'h0);

        // reserved opcode: read only
        preload(10'd4, 32'h55);
        do_cycle(1, 10'd4, 0, 32'h1234, 4'hF, 4'd12);
        idle();
        @(negedge clk); chk("lit_rsv_old", rdata_o, 32'h55);
        chk("lit_rsv_noreq", {31'h0, sram_req_o}, 32'h0);
        idle();
        chk("lit_rsv_mem", mem[4], 32'h55);

        // reset during AMO write-back
        preload(10'd9, 32'h1);
        do_cycle(1, 10'd9, 0, 32'hAB, 4'hF, 4'd1);
        rst_lvl = 0;
        idle();
        @(negedge clk); chk("lit_rst_sreq", {31'h0, sram_req_o}, 32'h0);
        chk("lit_rst_rdata", rdata_o, 32'h0);
        idle();
        rst_lvl = 1;
        do_cycle(1, 10'd9, 0, '0, 4'h0, 4'd0);
        @(negedge clk); chk("lit_post_rst_gnt", {31'h0, gnt_o}, 32'h1);
        idle();
        @(negedge clk); chk("lit_post_rst_rd", rdata_o, 32'h1);
        chk("lit_rst_mem", mem[9], 32'h1);

        // randomized traffic on a small address window
        for (int n = 0; n < 400; n++) begin
            logic [3:0] op;
            op = ($urandom % 6 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            do_cycle(($urandom % 4) != 0, 10'($urandom % 16), 1'($urandom % 2),
                     $urandom, 4'($urandom % 16), op);
        end
        idle(); idle();
        for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
